mii_rx_deframer: RTL and testbench

Receive-side companion to the 4-bit packet generator and CRC checker. It samples an MII nibble stream (TX loopback or PHY RX) once per MII strobe on the fast system clock. It strips preamble and SFD, packs nibbles into bytes (low nibble first), and emits a byte stream with start-of-frame and end-of-frame markers. It also reports frame length and length/framing errors and keeps good/bad frame counters; CRC is left to the CRC checker running in parallel.

---
 rtl/eth_rx_pkg.sv | 19 +
 rtl/mii_rx_deframer.sv | 211 +++++++++++++++++++++
 tb/tb_mii_rx_deframer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_rx_pkg.sv
// Shared definitions for the Ethernet receive path: deframer state encoding,
// preamble/SFD nibble values and default frame-length limits.
package eth_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        DROP = 2'd3
    } rx_state_e;

    localparam logic [3:0] PRE_NIB    = 4'h5;
    localparam logic [3:0] SFD_HI_NIB = 4'hD;

    localparam int DEF_MIN_LEN     = 64;
    localparam int DEF_MAX_LEN     = 1518;
    localparam int DEF_MAX_PRE_NIB = 15;

endpackage

// File: rtl/mii_rx_deframer.sv
// MII receive deframer: strips preamble/SFD, packs nibbles into bytes (low nibble
// first) and emits a byte stream with sof/eof markers, length/error flags and counters.
module mii_rx_deframer
    import eth_rx_pkg::*;
#(
    parameter int MIN_LEN     = DEF_MIN_LEN,
    parameter int MAX_LEN     = DEF_MAX_LEN,
    parameter int MAX_PRE_NIB = DEF_MAX_PRE_NIB
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_mii_ce,
    input  logic        io_mii_en,
    input  logic [3:0]  io_mii_data,
    output logic        io_out_valid,
    output logic [7:0]  io_out_data,
    output logic        io_out_sof,
    output logic        io_out_eof,
    output logic        io_out_err,
    output logic [15:0] io_frame_len,
    input  logic        io_cnt_clr,
    output logic [31:0] io_good_count,
    output logic [31:0] io_err_count
);

    localparam int              PRE_W     = $clog2(MAX_PRE_NIB + 2);
    localparam logic [PRE_W-1:0] MAX_PRE_L = PRE_W'(MAX_PRE_NIB);
    localparam logic [15:0]     MIN_LEN_L = 16'(MIN_LEN);
    localparam logic [15:0]     MAX_LEN_L = 16'(MAX_LEN);

    rx_state_e        state_q, state_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             phase_q, phase_d;        // 1: low nibble held, waiting for high
    logic [3:0]       lo_nib_q, lo_nib_d;
    logic             pend_q, pend_d;          // one-byte holdback so eof marks the true last byte
    logic [7:0]       pend_data_q, pend_data_d;
    logic             first_q, first_d;
    logic [15:0]      len_q, len_d;

    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_sof_q, out_sof_d;
    logic             out_eof_q, out_eof_d;
    logic             out_err_q, out_err_d;
    logic [15:0]      frame_len_q, frame_len_d;
    logic [31:0]      good_cnt_q, good_cnt_d;
    logic [31:0]      err_cnt_q, err_cnt_d;

    logic             good_inc;
    logic             err_inc;
    logic             frame_bad;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= DROP;
            pre_cnt_q   <= '0;
            phase_q     <= 1'b0;
            lo_nib_q    <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            first_q     <= 1'b0;
            len_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_err_q   <= 1'b0;
            frame_len_q <= '0;
            good_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            phase_q     <= phase_d;
            lo_nib_q    <= lo_nib_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            first_q     <= first_d;
            len_q       <= len_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            out_err_q   <= out_err_d;
            frame_len_q <= frame_len_d;
            good_cnt_q  <= good_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        phase_d     = phase_q;
        lo_nib_d    = lo_nib_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        first_d     = first_q;
        len_d       = len_q;
        // Pulse outputs drop on every cycle unless an emit below re-asserts them.
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_sof_d   = 1'b0;
        out_eof_d   = 1'b0;
        out_err_d   = 1'b0;
        frame_len_d = '0;
        good_inc    = 1'b0;
        err_inc     = 1'b0;
        frame_bad   = phase_q | (len_q < MIN_LEN_L) | (len_q > MAX_LEN_L);

        if (io_mii_ce) begin
            unique case (state_q)
                IDLE: begin
                    if (io_mii_en) begin
                        if (io_mii_data == PRE_NIB) begin
                            state_d   = PRE;
                            pre_cnt_d = PRE_W'(1);
                        end else begin
                            state_d = DROP;
                        end
                    end
                end

                PRE: begin
                    if (!io_mii_en) begin
                        state_d = IDLE;
                    end else if (io_mii_data == PRE_NIB) begin
                        if (pre_cnt_q >= MAX_PRE_L) begin
                            state_d = DROP;
                        end else begin
                            pre_cnt_d = pre_cnt_q + PRE_W'(1);
                        end
                    end else if (io_mii_data == SFD_HI_NIB && pre_cnt_q != '0) begin
                        state_d = DATA;
                        phase_d = 1'b0;
                        len_d   = '0;
                        first_d = 1'b1;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = DROP;
                    end
                end

                DATA: begin
                    if (io_mii_en) begin
                        if (!phase_q) begin
                            lo_nib_d = io_mii_data;
                            phase_d  = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            if (pend_q) begin
                                out_valid_d = 1'b1;
                                out_data_d  = pend_data_q;
                                out_sof_d   = first_q;
                                first_d     = 1'b0;
                            end
                            pend_d      = 1'b1;
                            pend_data_d = {io_mii_data, lo_nib_q};
                            if (len_q != 16'hFFFF) begin
                                len_d = len_q + 16'd1;
                            end
                        end
                    end else begin
                        state_d = IDLE;
                        phase_d = 1'b0;
                        pend_d  = 1'b0;
                        if (pend_q) begin
                            out_valid_d = 1'b1;
                            out_data_d  = pend_data_q;
                            out_sof_d   = first_q;
                            out_eof_d   = 1'b1;
                            out_err_d   = frame_bad;
                            frame_len_d = len_q;
                            good_inc    = !frame_bad;
                            err_inc     = frame_bad;
                        end else begin
                            // SFD seen but no complete byte: count as error, emit nothing.
                            err_inc = 1'b1;
                        end
                    end
                end

                DROP: begin
                    if (!io_mii_en) begin
                        state_d = IDLE;
                    end
                end

                default: state_d = DROP;
            endcase
        end

        if (io_cnt_clr) begin
            good_cnt_d = '0;
            err_cnt_d  = '0;
        end else begin
            good_cnt_d = good_cnt_q + {31'd0, good_inc};
            err_cnt_d  = err_cnt_q + {31'd0, err_inc};
        end
    end

    assign io_out_valid  = out_valid_q;
    assign io_out_data   = out_data_q;
    assign io_out_sof    = out_sof_q;
    assign io_out_eof    = out_eof_q;
    assign io_out_err    = out_err_q;
    assign io_frame_len  = frame_len_q;
    assign io_good_count = good_cnt_q;
    assign io_err_count  = err_cnt_q;

endmodule

// File: tb/tb_mii_rx_deframer.sv
// Scoreboard bench for mii_rx_deframer: a frame-level reference model queues the
// expected bytes; a monitor compares each output pulse against the queue.
module tb_mii_rx_deframer;

    localparam int MIN_LEN     = 64;
    localparam int MAX_LEN     = 1518;
    localparam int MAX_PRE_NIB = 15;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mii_ce = 1'b0;
    logic        mii_en = 1'b0;
    logic [3:0]  mii_data = 4'h0;
    logic        cnt_clr = 1'b0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sof;
    logic        out_eof;
    logic        out_err;
    logic [15:0] frame_len;
    logic [31:0] good_count;
    logic [31:0] err_count;

    mii_rx_deframer #(
        .MIN_LEN(MIN_LEN),
        .MAX_LEN(MAX_LEN),
        .MAX_PRE_NIB(MAX_PRE_NIB)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .io_mii_ce    (mii_ce),
        .io_mii_en    (mii_en),
        .io_mii_data  (mii_data),
        .io_out_valid (out_valid),
        .io_out_data  (out_data),
        .io_out_sof   (out_sof),
        .io_out_eof   (out_eof),
        .io_out_err   (out_err),
        .io_frame_len (frame_len),
        .io_cnt_clr   (cnt_clr),
        .io_good_count(good_count),
        .io_err_count (err_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        bit         sof;
        bit         eof;
        bit         err;
        int         len;
        int         good;
        int         errc;
    } exp_t;

    exp_t       sbq[$];
    logic [3:0] nq[$];
    int         m_good = 0;
    int         m_err  = 0;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_bytes  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor: every output pulse is matched against the head of the scoreboard.
    initial begin
        bit prev_v = 1'b0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (prev_v) chk("pulse_width", {63'd0, out_valid}, 64'd0);
            prev_v = out_valid;
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_byte", {56'd0, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    n_bytes++;
                    chk("byte_data", {56'd0, out_data}, {56'd0, e.data});
                    chk("byte_sof", {63'd0, out_sof}, {63'd0, e.sof});
                    chk("byte_eof", {63'd0, out_eof}, {63'd0, e.eof});
                    if (e.eof) begin
                        $display("frame end: len=%0d err=%0b good=%0d errc=%0d", frame_len, out_err, good_count, err_count);
                        chk("eof_err", {63'd0, out_err}, {63'd0, e.err});
                        chk("eof_len", {48'd0, frame_len}, 64'(e.len));
                        chk("eof_good_count", {32'd0, good_count}, 64'(e.good));
                        chk("eof_err_count", {32'd0, err_count}, 64'(e.errc));
                    end
                end
            end
        end
    end

    // Frame-level reference: parse preamble/SFD from the whole nibble list, then
    // derive bytes, length and error from the counts.
    task automatic model_frame(input bit clr);
        int   i = 0;
        int   npre = 0;
        int   ndat;
        int   nbytes;
        bit   bad;
        exp_t e;
        bit   framed;
        while (i < nq.size() && nq[i] == 4'h5) begin
            npre++;
            i++;
        end
        framed = (npre >= 1) && (npre <= MAX_PRE_NIB) && (i < nq.size()) && (nq[i] == 4'hD);
        if (framed) begin
            i++;
            ndat   = nq.size() - i;
            nbytes = ndat / 2;
            if (nbytes == 0) begin
                m_err++;
            end else begin
                bad = (ndat % 2 != 0) || (nbytes < MIN_LEN) || (nbytes > MAX_LEN);
                if (bad) m_err++;
                else m_good++;
                if (clr) begin
                    m_good = 0;
                    m_err  = 0;
                end
                for (int b = 0; b < nbytes; b++) begin
                    e.data = {nq[i + 2*b + 1], nq[i + 2*b]};
                    e.sof  = (b == 0);
                    e.eof  = (b == nbytes - 1);
                    e.err  = bad;
                    e.len  = (nbytes > 65535) ? 65535 : nbytes;
                    e.good = m_good;
                    e.errc = m_err;
                    sbq.push_back(e);
                end
            end
        end
        if (clr) begin
            m_good = 0;
            m_err  = 0;
        end
    endtask

    task automatic send_nib(input bit en, input logic [3:0] d, input bit clr);
        @(negedge clock);
        mii_ce   = 1'b1;
        mii_en   = en;
        mii_data = d;
        cnt_clr  = clr;
        @(negedge clock);
        mii_ce  = 1'b0;
        cnt_clr = 1'b0;
        repeat (6) @(negedge clock);
    endtask

    task automatic build_seq(input int npre, input int ndat, input bit incr);
        int b;
        nq.delete();
        for (int k = 0; k < npre; k++) nq.push_back(4'h5);
        nq.push_back(4'hD);
        for (int k = 0; k < ndat; k++) begin
            b = (k / 2) & 255;
            if (!incr) nq.push_back(4'($urandom_range(0, 15)));
            else if (k % 2 == 0) nq.push_back(4'(b));
            else nq.push_back(4'(b >> 4));
        end
    endtask

    task automatic send_frame(input string nm, input bit clr);
        model_frame(clr);
        for (int k = 0; k < nq.size(); k++) send_nib(1'b1, nq[k], 1'b0);
        send_nib(1'b0, 4'h0, clr);
        send_nib(1'b0, 4'h0, 1'b0);
        send_nib(1'b0, 4'h0, 1'b0);
        $display("frame %s: nibbles=%0d good=%0d errc=%0d", nm, nq.size(), good_count, err_count);
        chk({nm, "_good_count"}, {32'd0, good_count}, 64'(m_good));
        chk({nm, "_err_count"}, {32'd0, err_count}, 64'(m_err));
        chk({nm, "_drained"}, 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        exp_t e;
        // Reset state.
        repeat (3) @(negedge clock);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_good", {32'd0, good_count}, 64'd0);
        chk("rst_err", {32'd0, err_count}, 64'd0);
        chk("rst_len", {48'd0, frame_len}, 64'd0);
        reset = 1'b1;
        send_nib(1'b0, 4'h0, 1'b0);

        build_seq(15, 128, 1'b1);  send_frame("good64", 1'b0);
        build_seq(15, 120, 1'b1);  send_frame("short60", 1'b0);
        build_seq(15, 129, 1'b1);  send_frame("odd_nibble", 1'b0);

        build_seq(4, 128, 1'b1);
        nq[2] = 4'hA;
        send_frame("bad_preamble", 1'b0);
        build_seq(7, 130, 1'b0);   send_frame("after_drop", 1'b0);
        build_seq(16, 128, 1'b1);  send_frame("long_preamble", 1'b0);
        build_seq(2, 0, 1'b0);     send_frame("sfd_only", 1'b0);
        build_seq(2, 1, 1'b0);     send_frame("one_nibble", 1'b0);
        build_seq(1, 2, 1'b0);     send_frame("one_byte", 1'b0);

        // Reset mid-frame with en held high: 10 bytes in, 9 already emitted.
        build_seq(15, 20, 1'b0);
        for (int b = 0; b < 9; b++) begin
            e.data = {nq[16 + 2*b + 1], nq[16 + 2*b]};
            e.sof = (b == 0); e.eof = 1'b0; e.err = 1'b0;
            e.len = 0; e.good = 0; e.errc = 0;
            sbq.push_back(e);
        end
        for (int k = 0; k < nq.size(); k++) send_nib(1'b1, nq[k], 1'b0);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        m_good = 0;
        m_err  = 0;
        $display("mid-frame reset: valid=%0b good=%0d errc=%0d", out_valid, good_count, err_count);
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_eof", {63'd0, out_eof}, 64'd0);
        chk("midrst_good", {32'd0, good_count}, 64'd0);
        chk("midrst_err", {32'd0, err_count}, 64'd0);
        chk("midrst_pending", 64'(sbq.size()), 64'd0);
        for (int k = 0; k < 10; k++) send_nib(1'b1, 4'h5, 1'b0);
        send_nib(1'b0, 4'h0, 1'b0);
        send_nib(1'b0, 4'h0, 1'b0);
        chk("ignored_tail", 64'(sbq.size()), 64'd0);
        build_seq(15, 128, 1'b1);  send_frame("post_reset", 1'b0);

        build_seq(15, 128, 1'b1);  send_frame("clr_at_eof", 1'b1);
        build_seq(15, 3038, 1'b1); send_frame("len1519", 1'b0);

        for (int r = 0; r < 20; r++) begin
            build_seq($urandom_range(1, 16), $urandom_range(0, 170), 1'b0);
            if (r % 5 == 4) nq[0] = 4'hA;
            send_frame($sformatf("rand%0d", r), ($urandom_range(0, 5) == 0));
        end

        repeat (20) @(negedge clock);
        chk("final_drained", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
